// File: rtl/dwrr_input_scheduler.sv
// dwrr_input_scheduler: deficit-weighted round-robin merge of the
// four even rx queues onto one stream, whole packets at a time.
module dwrr_input_scheduler #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH_BITS = 4,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(8'hFF),
  parameter int LEN_POS         = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data_0,
  input  logic [CTRL_WIDTH-1:0] in_ctrl_0,
  input  logic                  in_wr_0,
  output logic                  in_rdy_0,
  input  logic [DATA_WIDTH-1:0] in_data_2,
  input  logic [CTRL_WIDTH-1:0] in_ctrl_2,
  input  logic                  in_wr_2,
  output logic                  in_rdy_2,
  input  logic [DATA_WIDTH-1:0] in_data_4,
  input  logic [CTRL_WIDTH-1:0] in_ctrl_4,
  input  logic                  in_wr_4,
  output logic                  in_rdy_4,
  input  logic [DATA_WIDTH-1:0] in_data_6,
  input  logic [CTRL_WIDTH-1:0] in_ctrl_6,
  input  logic                  in_wr_6,
  output logic                  in_rdy_6,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [15:0]           quantum_0,
  input  logic [15:0]           quantum_2,
  input  logic [15:0]           quantum_4,
  input  logic [15:0]           quantum_6,
  output logic [1:0]            active_port,
  output logic                  proto_err
);

  localparam int WW    = DATA_WIDTH + CTRL_WIDTH;
  localparam int AW    = FIFO_DEPTH_BITS;
  localparam int DEPTH = 1 << AW;

  typedef logic [AW:0] occ_t;

  localparam occ_t FULL    = occ_t'(DEPTH);
  localparam occ_t RDY_LIM = occ_t'(DEPTH - 2);
  localparam occ_t ONE     = occ_t'(1);

  localparam logic [1:0] S_SCAN  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;

  logic [WW-1:0] wr_word [4];
  logic [WW-1:0] head    [4];
  logic [15:0]   quantum [4];
  occ_t          occ     [4];
  logic [3:0]    wr_en;
  logic [3:0]    empty;
  logic [3:0]    pop;
  logic [3:0]    rdy;

  assign wr_word[0] = {in_ctrl_0, in_data_0};
  assign wr_word[1] = {in_ctrl_2, in_data_2};
  assign wr_word[2] = {in_ctrl_4, in_data_4};
  assign wr_word[3] = {in_ctrl_6, in_data_6};
  assign wr_en      = {in_wr_6, in_wr_4, in_wr_2, in_wr_0};

  assign quantum[0] = quantum_0;
  assign quantum[1] = quantum_2;
  assign quantum[2] = quantum_4;
  assign quantum[3] = quantum_6;

  assign in_rdy_0 = rdy[0];
  assign in_rdy_2 = rdy[1];
  assign in_rdy_4 = rdy[2];
  assign in_rdy_6 = rdy[3];

  for (genvar k = 0; k < 4; k++) begin : g_fifo
    logic [WW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    occ_t          cnt;
    logic          push;

    // a write into a full FIFO is silently lost
    assign push     = wr_en[k] && (cnt != FULL);
    assign head[k]  = mem[rptr];
    assign occ[k]   = cnt;
    assign empty[k] = (cnt == '0);
    assign rdy[k]   = (cnt < RDY_LIM);

    always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wr_word[k];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push)   wptr <= wptr + 1'b1;
        if (pop[k]) rptr <= rptr + 1'b1;
        case ({push, pop[k]})
          2'b10:   cnt <= cnt + ONE;
          2'b01:   cnt <= cnt - ONE;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  logic [1:0]            state;
  logic [1:0]            p;
  logic [15:0]           deficit [4];
  logic                  in_body;
  logic [WW-1:0]         hd;
  logic [CTRL_WIDTH-1:0] hctrl;
  logic [15:0]           hlen;
  logic [15:0]           dcur;
  logic [16:0]           sum;
  logic [15:0]           credit;
  logic                  send_pop;
  logic                  is_eop;

  assign hd       = head[p];
  assign hctrl    = hd[WW-1 -: CTRL_WIDTH];
  assign hlen     = hd[LEN_POS +: 16];
  assign dcur     = deficit[p];
  assign sum      = {1'b0, dcur} + {1'b0, quantum[p]};
  assign credit   = sum[16] ? 16'hFFFF : sum[15:0];
  assign send_pop = (state == S_SEND) && out_rdy && !empty[p];
  // EOP: first non-zero ctrl after a body word
  assign is_eop   = in_body && (hctrl != '0);

  always_comb begin
    pop    = '0;
    pop[p] = send_pop;
  end

  assign active_port = p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_SCAN;
      p         <= '0;
      in_body   <= 1'b0;
      proto_err <= 1'b0;
      out_wr    <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      for (int i = 0; i < 4; i++) deficit[i] <= '0;
    end else begin
      out_wr <= send_pop;
      if (send_pop) begin
        out_data <= hd[DATA_WIDTH-1:0];
        out_ctrl <= hctrl;
      end
      unique case (1'b1)
        (state == S_SCAN): begin
          if (quantum[p] == '0 || empty[p]) begin
            deficit[p] <= '0;
            p          <= p + 2'd1;
          end else begin
            deficit[p] <= credit;
            state      <= S_CHECK;
          end
        end
        (state == S_CHECK): begin
          in_body <= 1'b0;
          if (hctrl != IOQ_CTRL) begin
            proto_err <= 1'b1;
            state     <= S_SEND;
          end else if (hlen <= dcur) begin
            deficit[p] <= dcur - hlen;
            state      <= S_SEND;
          end else begin
            p     <= p + 2'd1;
            state <= S_SCAN;
          end
        end
        (state == S_SEND): begin
          if (send_pop) begin
            if (is_eop) begin
              in_body <= 1'b0;
              if (occ[p] > ONE) begin
                state <= S_CHECK;
              end else begin
                deficit[p] <= '0;
                p          <= p + 2'd1;
                state      <= S_SCAN;
              end
            end else if (hctrl == '0) begin
              in_body <= 1'b1;
            end
          end
        end
        default: state <= S_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_dwrr_input_scheduler.sv
// tb_dwrr_input_scheduler: random packet batches against a
// queue-level DWRR reference model, plus directed latency/reset cases.
module tb_dwrr_input_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] din [4];
  logic [7:0]  cin [4];
  logic [3:0]  wr = '0;
  logic [3:0]  rdy;
  logic [15:0] q [4];
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic        proto_err;
  logic [1:0]  active_port;

  int n_chk = 0;
  int n_err = 0;
  int edges = 0;
  int rdy_mode = 0;

  logic [71:0] got [$];
  logic [71:0] exp_q [$];
  logic [71:0] fq [4][$];
  int          plen [4][$];
  int          occ [4];
  bit          perr;

  dwrr_input_scheduler dut (
    .clk(clk), .reset(reset),
    .in_data_0(din[0]), .in_ctrl_0(cin[0]),
    .in_wr_0(wr[0]), .in_rdy_0(rdy[0]),
    .in_data_2(din[1]), .in_ctrl_2(cin[1]),
    .in_wr_2(wr[1]), .in_rdy_2(rdy[1]),
    .in_data_4(din[2]), .in_ctrl_4(cin[2]),
    .in_wr_4(wr[2]), .in_rdy_4(rdy[2]),
    .in_data_6(din[3]), .in_ctrl_6(cin[3]),
    .in_wr_6(wr[3]), .in_rdy_6(rdy[3]),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .out_wr(out_wr), .out_rdy(out_rdy),
    .quantum_0(q[0]), .quantum_2(q[1]),
    .quantum_4(q[2]), .quantum_6(q[3]),
    .active_port(active_port),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  always @(negedge clk) begin
    if (!reset && out_wr) got.push_back({out_ctrl, out_data});
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = 1'($urandom_range(0, 1));
        default: out_rdy = ~out_rdy;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(string tag, logic [71:0] g, logic [71:0] e);
    n_chk++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, g, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr = '0;
    for (int k = 0; k < 4; k++) begin
      q[k] = '0;
      din[k] = '0;
      cin[k] = '0;
      occ[k] = 0;
      fq[k].delete();
      plen[k].delete();
    end
    #1;
    chk("rst_out_wr", out_wr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_active_port", active_port, 0);
    chk("rst_in_rdy", rdy, 4'hF);
    tick();
    tick();
    reset = 1'b0;
    got.delete();
  endtask

  task automatic wr_word(int k, logic [71:0] w);
    chk("in_rdy", rdy[k], occ[k] < 14);
    din[k] = w[63:0];
    cin[k] = w[71:64];
    wr[k] = 1'b1;
    tick();
    wr[k] = 1'b0;
    if (occ[k] < 16) occ[k]++;
  endtask

  task automatic load_port(int k, int npk);
    int nw;
    int len;
    logic [71:0] w;
    for (int i = 0; i < npk; i++) begin
      nw = $urandom_range(3, 5);
      if (occ[k] + nw > 16) break;
      len = $urandom_range(40, 1500);
      w = {8'hFF, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) w[71:64] = 8'h01;
      w[15:0] = 16'(len);
      fq[k].push_back(w);
      wr_word(k, w);
      for (int j = 0; j < nw - 2; j++) begin
        w = {8'h00, $urandom, $urandom};
        fq[k].push_back(w);
        wr_word(k, w);
      end
      w = {8'($urandom_range(1, 255)), $urandom, $urandom};
      fq[k].push_back(w);
      wr_word(k, w);
      plen[k].push_back(nw);
    end
    // a word offered to a full FIFO must vanish
    if (occ[k] == 16 && $urandom_range(0, 1) == 1)
      wr_word(k, {8'hFF, 64'hDEAD_BEEF_0000_0010});
  endtask

  task automatic run_model(int start);
    int p;
    int rem;
    int n;
    int len;
    int def [4];
    logic [71:0] h;
    p = start;
    perr = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) def[k] = 0;
    forever begin
      rem = 0;
      for (int k = 0; k < 4; k++)
        if (q[k] != 0) rem += fq[k].size();
      if (rem == 0) break;
      if (q[p] == 0 || fq[p].size() == 0) begin
        def[p] = 0;
        p = (p + 1) % 4;
        continue;
      end
      def[p] = def[p] + int'(q[p]);
      if (def[p] > 65535) def[p] = 65535;
      forever begin
        h = fq[p][0];
        len = int'(h[15:0]);
        if (h[71:64] == 8'hFF) begin
          if (len > def[p]) begin
            p = (p + 1) % 4;
            break;
          end
          def[p] -= len;
        end else begin
          perr = 1'b1;
        end
        n = plen[p].pop_front();
        repeat (n) exp_q.push_back(fq[p].pop_front());
        if (fq[p].size() == 0) begin
          def[p] = 0;
          p = (p + 1) % 4;
          break;
        end
      end
    end
  endtask

  task automatic run_batch(int mode);
    int st;
    int t;
    int r;
    logic [15:0] qa [4];
    do_reset();
    rdy_mode = mode;
    for (int k = 0; k < 4; k++) load_port(k, $urandom_range(0, 4));
    for (int k = 0; k < 4; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      qa[k] = 16'h0000;
      else if (r == 1) qa[k] = 16'hFFFF;
      else             qa[k] = 16'($urandom_range(100, 1600));
    end
    st = edges % 4;
    chk("start_port", active_port, st);
    for (int k = 0; k < 4; k++) q[k] = qa[k];
    run_model(st);
    t = 0;
    while (got.size() < exp_q.size() && t < 4000) begin
      tick();
      t++;
    end
    chk("drain_in_time", t < 4000, 1);
    repeat (30) tick();
    chk("nwords", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk("word", got[i], exp_q[i]);
    chk("proto_err", proto_err, perr);
    for (int k = 0; k < 4; k++)
      chk("rdy_after", rdy[k], (q[k] == 0) ? (occ[k] < 14) : 1);
  endtask

  task automatic latency_test();
    int t;
    rdy_mode = 0;
    do_reset();
    q[1] = 16'd1500;
    t = 0;
    while (edges % 4 != 0 && t < 8) begin
      tick();
      t++;
    end
    chk("lat_port", active_port, 0);
    din[1] = 64'h0123_4567_89AB_0010;
    cin[1] = 8'hFF;
    wr[1] = 1'b1;
    tick();
    din[1] = 64'h1111_2222_3333_4444;
    cin[1] = 8'h00;
    tick();
    din[1] = 64'h5555_6666_7777_8888;
    cin[1] = 8'h10;
    tick();
    wr[1] = 1'b0;
    @(negedge clk);
    chk("lat_t3_idle", out_wr, 0);
    tick();
    @(negedge clk);
    chk("lat_t4_wr", out_wr, 1);
    chk("lat_hdr", {out_ctrl, out_data}, 72'hFF_0123_4567_89AB_0010);
    tick();
    @(negedge clk);
    chk("lat_t5_wr", out_wr, 1);
    chk("lat_body", {out_ctrl, out_data}, 72'h00_1111_2222_3333_4444);
    tick();
    @(negedge clk);
    chk("lat_t6_wr", out_wr, 1);
    chk("lat_eop", {out_ctrl, out_data}, 72'h10_5555_6666_7777_8888);
    tick();
    @(negedge clk);
    chk("lat_t7_idle", out_wr, 0);
  endtask

  task automatic mid_reset_test();
    int t;
    rdy_mode = 0;
    do_reset();
    load_port(0, 4);
    q[0] = 16'd1500;
    t = 0;
    while (got.size() < 2 && t < 200) begin
      tick();
      t++;
    end
    chk("mid_started", got.size() >= 2, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_wr", out_wr, 0);
    chk("mid_rst_in_rdy", rdy, 4'hF);
    tick();
    tick();
    reset = 1'b0;
    got.delete();
    repeat (20) tick();
    chk("mid_post_words", got.size(), 0);
    chk("mid_post_rdy", rdy, 4'hF);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      din[k] = '0;
      cin[k] = '0;
      q[k] = '0;
    end
    latency_test();
    for (int b = 0; b < 24; b++) run_batch(b % 3);
    mid_reset_test();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
